// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and ASCII constants for the console UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PFX_ID    = 2'd1,
    PFX_COLON = 2'd2,
    LOCKED    = 2'd3
  } arb_state_e;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set bit of i_req after i_ptr, with wrap-around
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_cand;

  // Candidates are visited at distance 1..N from i_ptr, so i_ptr itself has lowest priority.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = W'((int'(i_ptr) + k) % N);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, line-locked sharing of the console UART TX channel.
// Define UART_ARB_PREFIX_EN to emit "<id>:" ahead of every granted line.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ      = 2,
  parameter int  LOCK_TIMEOUT = 1024,
  parameter int  TO_W         = 11,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready,
  output logic [ID_W-1:0]      owner_id,
  output logic                 locked
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_owner_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic [7:0]      r_tx_data;
  logic [7:0]      w_tx_data_nxt;
  logic            r_tx_valid;
  logic            w_tx_valid_nxt;

  logic            w_out_free;
  logic            w_owner_valid;
  logic [7:0]      w_owner_data;
  logic            w_xfer;
  logic            w_pick_found;
  logic [ID_W-1:0] w_pick_idx;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_out_free = !r_tx_valid || uart_tx_ready;

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = 8'h00;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == ID_W'(i)) begin
        w_owner_valid = req_valid[i];
        w_owner_data  = req_data[8*i +: 8];
        req_ready[i]  = (r_state == LOCKED) && w_out_free;
      end
    end
  end

  assign w_xfer = (r_state == LOCKED) && w_out_free && w_owner_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt      = r_cnt;
    w_tx_valid_nxt = r_tx_valid && !uart_tx_ready;
    w_tx_data_nxt  = r_tx_data;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_pick_found) begin
          w_owner_nxt = w_pick_idx;
`ifdef UART_ARB_PREFIX_EN
          w_state_nxt = PFX_ID;
`else
          w_state_nxt = LOCKED;
`endif
        end
      end

`ifdef UART_ARB_PREFIX_EN
      PFX_ID: begin
        w_cnt_nxt = '0;
        if (w_out_free) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = ascii_digit(4'(r_owner));
          w_state_nxt    = PFX_COLON;
        end
      end

      PFX_COLON: begin
        w_cnt_nxt = '0;
        if (w_out_free) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = ASCII_COLON;
          w_state_nxt    = LOCKED;
        end
      end
`endif

      LOCKED: begin
        if (w_xfer) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = w_owner_data;
          w_cnt_nxt      = '0;
          if (w_owner_data == ASCII_NL) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_owner;
          end
        end else if (!w_owner_valid && (LOCK_TIMEOUT != 0)) begin
          // Only an idle owner ages the lock; a stalled UART never does.
          if (r_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_owner;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + TO_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  assign uart_tx_data  = r_tx_data;
  assign uart_tx_valid = r_tx_valid;
  assign owner_id      = r_owner;
  assign locked        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (NUM_REQ=2, LOCK_TIMEOUT=16)
module tb_uart_tx_arbiter;

  localparam int NR = 2;
`ifdef UART_ARB_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [7:0]      uart_tx_data;
  logic            uart_tx_valid;
  logic            uart_tx_ready;
  logic            owner_id;
  logic            locked;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic       watch_il;
  logic       rdy1_seen;
  logic       stall_bad;
  string      e;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .LOCK_TIMEOUT (16),
    .TO_W         (11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .owner_id      (owner_id),
    .locked        (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid[0]    = (src0.size() > 0);
    req_data[7:0]   = (src0.size() > 0) ? src0[0] : 8'h00;
    req_valid[1]    = (src1.size() > 0);
    req_data[15:8]  = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (watch_il && req_ready[1] && src0.size() > 0) rdy1_seen = 1'b1;
      if (req_valid[0] && req_ready[0]) void'(src0.pop_front());
      if (req_valid[1] && req_ready[1]) void'(src1.pop_front());
      if (uart_tx_valid && uart_tx_ready) out_q.push_back(uart_tx_data);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic load0(input string s);
    for (int i = 0; i < s.len(); i++) src0.push_back(s[i]);
  endtask

  task automatic load1(input string s);
    for (int i = 0; i < s.len(); i++) src1.push_back(s[i]);
  endtask

  task automatic expect_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  function automatic string pick(input string with_pfx, input string plain);
    return (PFX != 0) ? with_pfx : plain;
  endfunction

  task automatic drain(input string tag);
    int k = 0;
    while ((src0.size() > 0 || src1.size() > 0 || uart_tx_valid || locked) && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 32'(k < 300), 32'd1);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) chk($sformatf("%s_byte%0d", tag, i), out_q[i], exp_q[i]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    uart_tx_ready = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    watch_il      = 1'b0;
    rdy1_seen     = 1'b0;
    stall_bad     = 1'b0;
    step();
    step();
    chk("rst_valid", uart_tx_valid, 1'b0);
    chk("rst_data", uart_tx_data, 8'h00);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_owner", owner_id, 1'b0);
    rst = 1'b0;

    // single source: first byte two cycles after valid rises, one byte per cycle
    load0("hi\n");
    drive();
    step();
    chk("t1_grant_locked", locked, 1'b1);
    chk("t1_grant_novalid", uart_tx_valid, 1'b0);
    chk("t1_grant_ready", req_ready, 2'b01);
    e = pick("0:hi\n", "hi\n");
    for (int i = 0; i < e.len(); i++) begin
      step();
      chk($sformatf("t1_byte%0d", i), {uart_tx_valid, uart_tx_data}, {1'b1, e[i]});
    end
    chk("t1_unlocked", locked, 1'b0);
    step();
    chk("t1_idle_valid", uart_tx_valid, 1'b0);
    out_q.delete();

    // requester 1 alone; afterwards rr_ptr points at 1
    load1("ok\n");
    drive();
    drain("t2");
    expect_str(pick("1:ok\n", "ok\n"));
    chk_out("t2_out");
    chk("t2_owner", owner_id, 1'b1);
    out_q.delete();

    // both request at once: req0 wins from rr_ptr=1, req1 waits for the newline
    load0("AB\n");
    load1("CD\n");
    watch_il = 1'b1;
    drive();
    drain("t3");
    watch_il = 1'b0;
    chk("t3_no_early_ready1", rdy1_seen, 1'b0);
    expect_str(pick("0:AB\n1:CD\n", "AB\nCD\n"));
    chk_out("t3_out");
    out_q.delete();

    // backpressure: hold a byte for 1000+ stalled cycles, lock must survive
    load0("pqr\n");
    load1("Z\n");
    drive();
    for (int k = 0; k < 10 && !(uart_tx_valid && uart_tx_data == 8'h70); k++) step();
    chk("t4_first", {uart_tx_valid, uart_tx_data}, {1'b1, 8'h70});
    uart_tx_ready = 1'b0;
    step();
    chk("t4_stall1", {uart_tx_valid, uart_tx_data}, {1'b1, 8'h70});
    step();
    chk("t4_stall2", {uart_tx_valid, uart_tx_data}, {1'b1, 8'h70});
    for (int k = 0; k < 1000; k++) begin
      step();
      if (!uart_tx_valid || uart_tx_data != 8'h70 || !locked || owner_id != 1'b0 || req_ready != 2'b00)
        stall_bad = 1'b1;
    end
    chk("t4_stall_stable", stall_bad, 1'b0);
    chk("t4_lock_kept", {locked, owner_id}, {1'b1, 1'b0});
    uart_tx_ready = 1'b1;
    drain("t4");
    expect_str(pick("0:pqr\n1:Z\n", "pqr\nZ\n"));
    chk_out("t4_out");
    out_q.delete();

    // timeout: req0 sends "X" then idles; release on the 16th idle cycle
    load0("X");
    load1("W\n");
    drive();
    for (int k = 0; k < 2 + PFX; k++) step();
    chk("t5_x", {uart_tx_valid, uart_tx_data}, {1'b1, 8'h58});
    for (int k = 0; k < 15; k++) step();
    chk("t5_held_15", {locked, owner_id}, {1'b1, 1'b0});
    step();
    chk("t5_released_16", locked, 1'b0);
    drain("t5");
    expect_str(pick("0:X1:W\n", "XW\n"));
    chk_out("t5_out");
    out_q.delete();

    // reset while a byte is stalled in the output register
    load1("mm\n");
    drive();
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 10 && !uart_tx_valid; k++) step();
    chk("t6_pre_owner", {uart_tx_valid, owner_id}, {1'b1, 1'b1});
    rst = 1'b1;
    src0.delete();
    src1.delete();
    step();
    chk("t6_valid", uart_tx_valid, 1'b0);
    chk("t6_locked", locked, 1'b0);
    chk("t6_owner", owner_id, 1'b0);
    chk("t6_data", uart_tx_data, 8'h00);
    rst = 1'b0;
    uart_tx_ready = 1'b1;
    out_q.delete();
    load0("a\n");
    load1("b\n");
    drive();
    step();
    chk("t6_restart_owner", {locked, owner_id}, {1'b1, 1'b1});
    drain("t6");
    expect_str(pick("1:b\n0:a\n", "b\na\n"));
    chk_out("t6_out");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
